// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: ADD SUB AND OR XOR NOR SHL SHR, one-cycle latency.
// In: clk_i rst_i valid_i a_i b_i op_i. Out: alu_o valid_o zero_o carry_o
// ovf_o neg_o. Define ALU_SAT_EN for unsigned-saturating ADD/SUB.
module alu_8bit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] alu_o,
  output logic       valid_o,
  output logic       zero_o,
  output logic       carry_o,
  output logic       ovf_o,
  output logic       neg_o
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  logic [7:0]  res_d, res_q;
  logic        c_d, c_q;
  logic        v_d, v_q;
  logic        z_d, z_q;
  logic        n_d, n_q;
  logic        valid_q;
  logic [8:0]  sum9, diff9;
  logic [15:0] shl16, shr16;

  // Shifts run in a 16-bit window so the last bit shifted
  // out lands at a fixed position (0 when shift is 0).
  assign sum9  = {1'b0, a_i} + {1'b0, b_i};
  assign diff9 = {1'b0, a_i} - {1'b0, b_i};
  assign shl16 = {8'h00, a_i} << b_i[2:0];
  assign shr16 = {a_i, 8'h00} >> b_i[2:0];

  always_comb begin
    res_d = 8'h00;
    c_d   = 1'b0;
    v_d   = 1'b0;
    unique case (op_e'(op_i))
      OP_ADD: begin
        res_d = sum9[7:0];
        c_d   = sum9[8];
        v_d   = (a_i[7] == b_i[7]) && (sum9[7] != a_i[7]);
`ifdef ALU_SAT_EN
        if (sum9[8]) res_d = 8'hFF;
`endif
      end
      OP_SUB: begin
        res_d = diff9[7:0];
        c_d   = diff9[8];
        v_d   = (a_i[7] != b_i[7]) && (diff9[7] != a_i[7]);
`ifdef ALU_SAT_EN
        if (diff9[8]) res_d = 8'h00;
`endif
      end
      OP_AND: res_d = a_i & b_i;
      OP_OR:  res_d = a_i | b_i;
      OP_XOR: res_d = a_i ^ b_i;
      OP_NOR: res_d = ~(a_i | b_i);
      OP_SHL: begin
        res_d = shl16[7:0];
        c_d   = shl16[8];
      end
      OP_SHR: begin
        res_d = shr16[15:8];
        c_d   = shr16[7];
      end
      default: res_d = 8'h00;
    endcase
    z_d = (res_d == 8'h00);
    n_d = res_d[7];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= 8'h00;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        res_q <= res_d;
        c_q   <= c_d;
        v_q   <= v_d;
        z_q   <= z_d;
        n_q   <= n_d;
      end
    end
  end

  assign alu_o   = res_q;
  assign valid_o = valid_q;
  assign zero_o  = z_q;
  assign carry_o = c_q;
  assign ovf_o   = v_q;
  assign neg_o   = n_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit against an integer reference model.
// Honours ALU_SAT_EN when defined for both bench and design.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'd0;
  logic [7:0] alu;
  logic       vo, zo, co, oo, no;

  int nvec = 0;
  int nerr = 0;
  logic [11:0] exp_q = 12'h000;

  alu_8bit dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vld),
    .a_i(a), .b_i(b), .op_i(op),
    .alu_o(alu), .valid_o(vo), .zero_o(zo),
    .carry_o(co), .ovf_o(oo), .neg_o(no)
  );

  always #5 clk = ~clk;

  // Returns {R, zero, carry, ovf, neg}.
  function automatic logic [11:0] model(int x, int y, int o);
    int r, sr, sx, sy, n;
    bit c, v;
    c = 0; v = 0;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    n = y % 8;
    case (o)
      0: begin
        r = x + y; c = (r > 255); r = r % 256;
        sr = sx + sy; v = (sr > 127) || (sr < -128);
`ifdef ALU_SAT_EN
        if (c) r = 255;
`endif
      end
      1: begin
        c = (x < y); r = (x - y + 256) % 256;
        sr = sx - sy; v = (sr > 127) || (sr < -128);
`ifdef ALU_SAT_EN
        if (c) r = 0;
`endif
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - (x | y);
      6: begin
        r = (x * (2 ** n)) % 256;
        c = (n == 0) ? 0 : ((x >> (8 - n)) & 1);
      end
      default: begin
        r = x / (2 ** n);
        c = (n == 0) ? 0 : ((x >> (n - 1)) & 1);
      end
    endcase
    return {r[7:0], r == 0, c, v, r >= 128};
  endfunction

  function automatic logic [12:0] obs();
    return {vo, alu, zo, co, oo, no};
  endfunction

  task automatic drive(input logic v, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] o);
    @(negedge clk);
    vld = v; a = x; b = y; op = o;
    @(posedge clk);
    #1;
    if (v && !rst) exp_q = model(int'(x), int'(y), int'(o));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
      nvec++;
      if (obs() !== 13'h0) begin
        nerr++;
        $display("FAIL reset got=%h want=%h", obs(), 13'h0);
      end
    end
    exp_q = 12'h000;
    rst = 1'b0;
    drive(1'b0, 8'h11, 8'h22, 3'd0);
    nvec++;
    if (obs() !== 13'h0) begin
      nerr++;
      $display("FAIL post_reset_idle got=%h want=%h", obs(), 13'h0);
    end
    drive(1'b1, 8'h02, 8'h0A, 3'd0);
    nvec++;
    if (obs() !== {1'b1, 12'h0C0} || obs() !== {1'b1, exp_q}) begin
      nerr++;
      $display("FAIL first_result got=%h want=%h", obs(), {1'b1, exp_q});
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [8] = '{8'h02, 8'h02, 8'h02, 8'h02,
                           8'h02, 8'h02, 8'h06, 8'h00};
    logic [7:0] tb [8] = '{8'h0A, 8'h0A, 8'h0A, 8'h0A,
                           8'h0A, 8'h0B, 8'h0A, 8'h0A};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ta[i], tb[i], 3'(i));
      nvec++;
      if (obs() !== {1'b1, exp_q}) begin
        nerr++;
        $display("FAIL directed_op%0d got=%h want=%h", i, obs(),
                 {1'b1, exp_q});
      end
    end
  endtask

  task automatic test_ovf_carry();
    logic [7:0] ta [3] = '{8'h7F, 8'hFF, 8'h80};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h01};
    logic [2:0] to [3] = '{3'd0, 3'd0, 3'd1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ta[i], tb[i], to[i]);
      nvec++;
      if (obs() !== {1'b1, exp_q}) begin
        nerr++;
        $display("FAIL ovf_carry%0d got=%h want=%h", i, obs(),
                 {1'b1, exp_q});
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
      nvec++;
      if (obs() !== {1'b0, exp_q}) begin
        nerr++;
        $display("FAIL hold%0d got=%h want=%h", i, obs(),
                 {1'b0, exp_q});
      end
    end
  endtask

`ifdef ALU_SAT_EN
  task automatic test_sat();
    drive(1'b1, 8'hF0, 8'h20, 3'd0);
    nvec++;
    if (obs() !== {1'b1, 8'hFF, 4'b0101}) begin
      nerr++;
      $display("FAIL sat_add got=%h want=%h", obs(),
               {1'b1, 8'hFF, 4'b0101});
    end
    drive(1'b1, 8'h05, 8'h09, 3'd1);
    nvec++;
    if (obs() !== {1'b1, 8'h00, 4'b1100}) begin
      nerr++;
      $display("FAIL sat_sub got=%h want=%h", obs(),
               {1'b1, 8'h00, 4'b1100});
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic v;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, 8'($urandom), 8'($urandom), 3'($urandom));
      nvec++;
      if (obs() !== {v, exp_q}) begin
        nerr++;
        $display("FAIL random%0d got=%h want=%h", i, obs(), {v, exp_q});
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'h01, 3'd0);
    exp_q = 12'h000;
    rst = 1'b0;
    nvec++;
    if (obs() !== 13'h0) begin
      nerr++;
      $display("FAIL reset_mid got=%h want=%h", obs(), 13'h0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ovf_carry();
    test_hold();
`ifdef ALU_SAT_EN
    test_sat();
`endif
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name:
alu_8bit

Overview:
- Registered 8-bit ALU; eight operations selected by a 3-bit opcode.
- Operands and opcode are sampled on a rising clock edge when valid_i is high; result and status flags are registered one cycle later.
- Used as the arithmetic/logic execution stage in small datapaths; produces a single result stream with a valid strobe.

Parameters:
- None. Data width is fixed at 8; opcode width is fixed at 3.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  operands/opcode valid this cycle
- a_i  input  8  operand A, unsigned/two's complement
- b_i  input  8  operand B
- op_i  input  3  operation select
- alu_o  output  8  registered result
- valid_o  output  1  alu_o/flags updated this cycle
- zero_o  output  1  alu_o == 0
- carry_o  output  1  carry/borrow/shifted-out bit
- ovf_o  output  1  signed overflow
- neg_o  output  1  alu_o[7]

Behaviour:
- One clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: alu_o=0x00, valid_o=0, zero_o=0, carry_o=0, ovf_o=0, neg_o=0. Reset wins over valid_i in the same cycle.
- Latency: exactly 1 cycle. valid_i high at edge N gives the result at edge N, visible with valid_o=1 after that edge. Back-to-back valid_i gives one result per cycle; no stall or backpressure.
- valid_i low: alu_o and all flags hold their last values; valid_o=0 next cycle.
- Opcodes (R = result):
  - 0 ADD: R=A+B mod 256; carry=bit 8 of the 9-bit sum; ovf=signed add overflow.
  - 1 SUB: R=A-B mod 256; carry=borrow (1 when A<B unsigned); ovf=signed sub overflow.
  - 2 AND: R=A&B.
  - 3 OR: R=A|B.
  - 4 XOR: R=A^B.
  - 5 NOR: R=~(A|B).
  - 6 SHL: R=A<<B[2:0], zero fill; carry=last bit shifted out (0 if shift amount is 0).
  - 7 SHR: R=A>>B[2:0], logical, zero fill; carry=last bit shifted out (0 if shift amount is 0).
- B[7:3] are ignored for shifts.
- Logic ops (2-5): carry=0, ovf=0. ovf=0 for shifts.
- zero_o and neg_o are computed from the final registered R.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD and SUB saturate unsigned. ADD with carry gives R=0xFF; SUB with borrow gives R=0x00. carry_o and ovf_o still report the unsaturated condition; zero/neg follow the saturated R.
- Undefined: ADD/SUB wrap modulo 256 as above.
- All other opcodes are identical with or without the macro.

Test Plan:
- Reset: assert rst_i 2 cycles with valid_i=1 -> alu_o=0x00, valid_o=0, all flags 0. Release rst_i -> first result appears 1 cycle after the first valid_i.
- A=0x02, B=0x0A, ops 0-4 back-to-back -> 0x0C, 0xF8 (carry=1, neg=1), 0x02, 0x0A, 0x08; valid_o high each cycle, delayed by 1 cycle.
- op5 A=0x02, B=0x0B -> 0xF4, neg=1. op6 A=0x06, B=0x0A -> 0x18, carry=0. op7 A=0x00, B=0x0A -> 0x00, zero=1.
- Overflow/carry: ADD 0x7F+0x01 -> 0x80, ovf=1, carry=0. ADD 0xFF+0x01 -> 0x00, carry=1, zero=1. SUB 0x80-0x01 -> 0x7F, ovf=1.
- Hold: valid_i=0 for 3 cycles with changing a_i/b_i/op_i -> alu_o and flags unchanged, valid_o=0.
- With ALU_SAT_EN: ADD 0xF0+0x20 -> 0xFF, carry=1. SUB 0x05-0x09 -> 0x00, carry=1, zero=1.
